// File: rtl/interrupt_priority_control.sv
// Multi-source IRQ front end: edge-latched pending bits, ICT qualification, arbitration, one offer at a time.
// Latency: edge -> pending +1 cycle -> grant/offer +2 cycles; held off by iEXCEPTION_LOCK in IDLE. Option: IRQ_CTRL_LEVEL_FILTER_EN.
`ifndef IRQ_NUM_INVALID_VECT
`define IRQ_NUM_INVALID_VECT 7'h7F
`endif

module interrupt_priority_control #(
    parameter int P_IRQ_SOURCES = 8,
    parameter int P_EXT_BASE    = 4
) (
    input  logic                     iCLOCK,
    input  logic                     inRESET,
    input  logic                     iRESET_SYNC,
    input  logic                     iICT_VALID,
    input  logic [5:0]               iICT_ENTRY,
    input  logic                     iICT_CONF_MASK,
    input  logic                     iICT_CONF_VALID,
    input  logic [1:0]               iICT_CONF_LEVEL,
    input  logic [1:0]               iPSR_IRQ_LEVEL,
    input  logic [P_IRQ_SOURCES-1:0] iEXT_REQ,
    output logic [P_IRQ_SOURCES-1:0] oEXT_ACK,
    input  logic                     iEXCEPTION_LOCK,
    output logic                     oEXCEPTION_ACTIVE,
    output logic [6:0]               oEXCEPTION_IRQ_NUM,
    output logic [31:0]              oEXCEPTION_IRQ_FI0R,
    input  logic                     iEXCEPTION_IRQ_ACK
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                   state_q, state_d;
    logic [P_IRQ_SOURCES-1:0] req_q, req_d;
    logic [P_IRQ_SOURCES-1:0] pend_q, pend_d;
    logic [P_IRQ_SOURCES-1:0] ack_q, ack_d;
    logic [P_IRQ_SOURCES-1:0] valid_q, valid_d;
    logic [P_IRQ_SOURCES-1:0] mask_q, mask_d;
    logic [6:0]               num_q, num_d;
    logic [5:0]               fi0r_q, fi0r_d;

    logic                     cand_any;
    logic                     sel_inv;
    logic [P_IRQ_SOURCES-1:0] sel_oh;
    logic [5:0]               sel_entry;

`ifdef IRQ_CTRL_LEVEL_FILTER_EN
    logic [1:0] level_q [P_IRQ_SOURCES];
    logic [1:0] level_d [P_IRQ_SOURCES];
`else
    logic unused_level;
    assign unused_level = ^{iPSR_IRQ_LEVEL, iICT_CONF_LEVEL};
`endif

    // Rank = {invalid, level}; strict '>' while scanning upward keeps the lowest index on ties.
    always_comb begin : arb
        logic       inv;
        logic       elig;
        logic [2:0] rank;
        logic [2:0] best_rank;
        inv       = 1'b0;
        elig      = 1'b0;
        rank      = '0;
        best_rank = '0;
        cand_any  = 1'b0;
        sel_inv   = 1'b0;
        sel_oh    = '0;
        sel_entry = '0;
        for (int k = 0; k < P_IRQ_SOURCES; k++) begin
            inv  = pend_q[k] && !valid_q[k];
`ifdef IRQ_CTRL_LEVEL_FILTER_EN
            elig = pend_q[k] && valid_q[k] && mask_q[k] && (level_q[k] > iPSR_IRQ_LEVEL);
            rank = {inv, level_q[k]};
`else
            elig = pend_q[k] && valid_q[k] && mask_q[k];
            rank = {inv, 2'b00};
`endif
            if ((inv || elig) && (!cand_any || rank > best_rank)) begin
                cand_any  = 1'b1;
                best_rank = rank;
                sel_inv   = inv;
                sel_oh    = '0;
                sel_oh[k] = 1'b1;
                sel_entry = 6'(k + P_EXT_BASE);
            end
        end
    end

    always_comb begin
        mask_d = mask_q;
`ifdef IRQ_CTRL_LEVEL_FILTER_EN
        level_d = level_q;
`endif
        for (int k = 0; k < P_IRQ_SOURCES; k++) begin
            if (iICT_VALID && iICT_ENTRY == 6'(k + P_EXT_BASE)) begin
                mask_d[k] = iICT_CONF_MASK;
`ifdef IRQ_CTRL_LEVEL_FILTER_EN
                level_d[k] = iICT_CONF_LEVEL;
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = iEXT_REQ;
        pend_d  = pend_q;
        ack_d   = '0;
        num_d   = num_q;
        fi0r_d  = fi0r_q;
        valid_d = valid_q;
        for (int k = 0; k < P_IRQ_SOURCES; k++) begin
            if (iICT_VALID && iICT_ENTRY == 6'(k + P_EXT_BASE)) begin
                valid_d[k] = iICT_CONF_VALID;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (cand_any && !iEXCEPTION_LOCK) begin
                    state_d = ST_WAIT;
                    ack_d   = sel_oh;
                    pend_d  = pend_q & ~sel_oh;
                    if (sel_inv) begin
                        num_d  = `IRQ_NUM_INVALID_VECT;
                        fi0r_d = sel_entry;
                    end else begin
                        num_d  = {1'b0, sel_entry};
                        fi0r_d = '0;
                    end
                end
            end
            default: begin
                if (iEXCEPTION_IRQ_ACK) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        pend_d = pend_d | (iEXT_REQ & ~req_q);
        // Edge history clears to all-ones so a line held high across reset is not a new request.
        if (iRESET_SYNC) begin
            state_d = ST_IDLE;
            req_d   = '1;
            pend_d  = '0;
            ack_d   = '0;
            num_d   = '0;
            fi0r_d  = '0;
            valid_d = '0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= ST_IDLE;
            req_q   <= '1;
            pend_q  <= '0;
            ack_q   <= '0;
            num_q   <= '0;
            fi0r_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            num_q   <= num_d;
            fi0r_q  <= fi0r_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge iCLOCK) begin
        mask_q <= mask_d;
`ifdef IRQ_CTRL_LEVEL_FILTER_EN
        level_q <= level_d;
`endif
    end

    assign oEXT_ACK            = ack_q;
    assign oEXCEPTION_ACTIVE   = (state_q == ST_WAIT) && !iEXCEPTION_IRQ_ACK;
    assign oEXCEPTION_IRQ_NUM  = (state_q == ST_WAIT) ? num_q : 7'd0;
    assign oEXCEPTION_IRQ_FI0R = (state_q == ST_WAIT) ? {26'd0, fi0r_q} : 32'd0;

endmodule

// File: tb/tb_interrupt_priority_control.sv
// Bench for interrupt_priority_control: vector table plus hand sequences, scoreboard of expected grants.
`ifndef IRQ_NUM_INVALID_VECT
`define IRQ_NUM_INVALID_VECT 7'h7F
`endif

module tb_interrupt_priority_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_sync = 1'b0;
    logic        ict_vld = 1'b0;
    logic [5:0]  ict_entry = '0;
    logic        ict_mask = 1'b0;
    logic        ict_valid = 1'b0;
    logic [1:0]  ict_level = '0;
    logic [1:0]  psr = '0;
    logic [7:0]  req = '0;
    logic [7:0]  ack;
    logic        lock = 1'b0;
    logic        active;
    logic [6:0]  num;
    logic [31:0] fi0r;
    logic        irq_ack = 1'b0;

    localparam logic [6:0] INV = `IRQ_NUM_INVALID_VECT;

    always #5 clk = ~clk;

    interrupt_priority_control #(.P_IRQ_SOURCES(8), .P_EXT_BASE(4)) dut (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync),
        .iICT_VALID(ict_vld), .iICT_ENTRY(ict_entry), .iICT_CONF_MASK(ict_mask),
        .iICT_CONF_VALID(ict_valid), .iICT_CONF_LEVEL(ict_level), .iPSR_IRQ_LEVEL(psr),
        .iEXT_REQ(req), .oEXT_ACK(ack), .iEXCEPTION_LOCK(lock),
        .oEXCEPTION_ACTIVE(active), .oEXCEPTION_IRQ_NUM(num),
        .oEXCEPTION_IRQ_FI0R(fi0r), .iEXCEPTION_IRQ_ACK(irq_ack)
    );

    typedef struct {
        logic [6:0]  num;
        logic [31:0] fi0r;
        logic [7:0]  ack;
    } exp_t;

    typedef struct {
        logic [7:0] req;
        int         n;
        exp_t       g[3];
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   errors = 0;
    int   checks = 0;
    int   waited;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ict_write(input logic [5:0] e, input logic v, input logic m, input logic [1:0] l);
        ict_vld = 1'b1; ict_entry = e; ict_valid = v; ict_mask = m; ict_level = l;
        tick();
        ict_vld = 1'b0;
    endtask

    task automatic raise(input logic [7:0] bits);
        req = req | bits;
        tick();
    endtask

    task automatic drop();
        req = '0;
        tick();
    endtask

    task automatic push(input logic [6:0] n, input logic [31:0] f, input logic [7:0] a);
        exp_t e;
        e.num = n; e.fi0r = f; e.ack = a;
        sb_q.push_back(e);
    endtask

    task automatic no_grant(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            chk(name, {31'd0, (|ack) | active}, 32'd0);
        end
    endtask

    // Wait for a grant, compare against the scoreboard head, then retire it with IRQ_ACK.
    task automatic service(output int w);
        exp_t e;
        bit   got;
        w   = 0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (|ack) got = 1'b1;
            else begin tick(); w++; end
        end
        if (!got) begin
            chk("grant_timeout", 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        if (sb_q.size() == 0) begin
            chk("unexpected_grant", {24'd0, ack}, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk("ack_onehot", {24'd0, ack}, {24'd0, e.ack});
        chk("active", {31'd0, active}, 32'd1);
        chk("num", {25'd0, num}, {25'd0, e.num});
        chk("fi0r", fi0r, e.fi0r);
        tick();
        chk("ack_pulse_end", {24'd0, ack}, 32'd0);
        chk("active_hold", {31'd0, active}, 32'd1);
        chk("num_hold", {25'd0, num}, {25'd0, e.num});
        irq_ack = 1'b1;
        #1;
        chk("active_on_irq_ack", {31'd0, active}, 32'd0);
        tick();
        irq_ack = 1'b0;
        chk("idle_num", {25'd0, num}, 32'd0);
        chk("idle_fi0r", fi0r, 32'd0);
    endtask

    function automatic vec_t mk(input logic [7:0] r, input int n,
                                input logic [6:0] n0, input logic [31:0] f0, input logic [7:0] a0,
                                input logic [6:0] n1, input logic [31:0] f1, input logic [7:0] a1,
                                input logic [6:0] n2, input logic [31:0] f2, input logic [7:0] a2);
        vec_t v;
        v.req = r; v.n = n;
        v.g[0].num = n0; v.g[0].fi0r = f0; v.g[0].ack = a0;
        v.g[1].num = n1; v.g[1].fi0r = f1; v.g[1].ack = a1;
        v.g[2].num = n2; v.g[2].fi0r = f2; v.g[2].ack = a2;
        return v;
    endfunction

    initial begin
        // Sources k -> ICT entry k+4. Entry 8 masked; entries 6 and 11 left invalid.
        vecs[0] = mk(8'h01, 1, 7'h04, 0, 8'h01, 0, 0, 0, 0, 0, 0);
`ifdef IRQ_CTRL_LEVEL_FILTER_EN
        vecs[1] = mk(8'h0A, 2, 7'h07, 0, 8'h08, 7'h05, 0, 8'h02, 0, 0, 0);
`else
        vecs[1] = mk(8'h0A, 2, 7'h05, 0, 8'h02, 7'h07, 0, 8'h08, 0, 0, 0);
`endif
        vecs[2] = mk(8'h04, 1, INV, 32'h6, 8'h04, 0, 0, 0, 0, 0, 0);
        vecs[3] = mk(8'h85, 3, INV, 32'h6, 8'h04, INV, 32'hB, 8'h80, 7'h04, 0, 8'h01);
        vecs[4] = mk(8'h41, 2, 7'h04, 0, 8'h01, 7'h0A, 0, 8'h40, 0, 0, 0);
        vecs[5] = mk(8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        #12;
        chk("reset_ack", {24'd0, ack}, 32'd0);
        chk("reset_active", {31'd0, active}, 32'd0);
        chk("reset_num", {25'd0, num}, 32'd0);
        chk("reset_fi0r", fi0r, 32'd0);
        rst_n = 1'b1;
        tick();

        ict_write(6'd4, 1, 1, 2'd2);
        ict_write(6'd5, 1, 1, 2'd1);
        ict_write(6'd6, 0, 1, 2'd3);
        ict_write(6'd7, 1, 1, 2'd3);
        ict_write(6'd8, 1, 0, 2'd3);
        ict_write(6'd9, 1, 1, 2'd0);
        ict_write(6'd10, 1, 1, 2'd2);
        ict_write(6'd11, 0, 0, 2'd0);

        for (int i = 0; i < 6; i++) begin
            for (int g = 0; g < vecs[i].n; g++) sb_q.push_back(vecs[i].g[g]);
            raise(vecs[i].req);
            if (vecs[i].n == 0) no_grant("masked_no_grant", 6);
            for (int g = 0; g < vecs[i].n; g++) service(waited);
            drop();
        end

        // Source 4 left pending while masked; unmasking releases it.
        push(7'h08, 0, 8'h10);
        ict_write(6'd8, 1, 1, 2'd3);
        service(waited);

        // Edge -> grant two edges later.
        push(7'h04, 0, 8'h01);
        raise(8'h01);
        chk("latency_pending_no_ack", {24'd0, ack}, 32'd0);
        service(waited);
        chk("latency_cycles", waited, 1);
        drop();

        lock = 1'b1;
        push(7'h04, 0, 8'h01);
        raise(8'h01);
        no_grant("lock_hold", 5);
        lock = 1'b0;
        service(waited);
        chk("lock_release_cycles", waited, 1);
        drop();

`ifdef IRQ_CTRL_LEVEL_FILTER_EN
        psr = 2'd2;
        raise(8'h01);
        no_grant("psr_filter", 5);
        push(7'h04, 0, 8'h01);
        psr = 2'd1;
        service(waited);
        chk("psr_release_cycles", waited, 1);
        psr = 2'd0;
        drop();
`endif

        // Async reset while an offer is outstanding.
        raise(8'h01);
        tick();
        chk("pre_reset_active", {31'd0, active}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_wait_active", {31'd0, active}, 32'd0);
        chk("reset_wait_num", {25'd0, num}, 32'd0);
        tick();
        rst_n = 1'b1;
        no_grant("no_regrant_held_high", 6);
        drop();
        push(INV, 32'h4, 8'h01);
        raise(8'h01);
        service(waited);
        drop();

        ict_write(6'd5, 1, 1, 2'd1);
        raise(8'h02);
        tick();
        chk("pre_sync_ack", {24'd0, ack}, 32'h02);
        rst_sync = 1'b1;
        tick();
        rst_sync = 1'b0;
        chk("sync_reset_active", {31'd0, active}, 32'd0);
        chk("sync_reset_num", {25'd0, num}, 32'd0);
        no_grant("sync_no_regrant", 4);
        drop();

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
